// File: rtl/fpu_pkg.sv
// Shared definitions for the single-precision divider: FSM states, IEEE-754
// constants, flag bit positions and operand classification helpers.
package fpu_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        ITER   = 3'd2,
        ROUND  = 3'd3,
        DONE   = 3'd4
    } div_state_t;

    localparam logic [9:0]  BIAS    = 10'd127;
    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    // flags = {invalid, div_by_zero, overflow, underflow}
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_DIV_ZERO  = 2;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_UNDERFLOW = 0;

    localparam logic [4:0] ITER_LAST = 5'd25;

    // Denormals have a zero exponent field and are flushed to zero.
    function automatic logic is_zero(input logic [31:0] x);
        return (x[30:23] == 8'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/fp_div_mant_iter.sv
// One radix-2 restoring division step on 24-bit mantissas.
module fp_div_mant_iter (
    input  logic [24:0] rem,
    input  logic [23:0] divisor,
    output logic [24:0] rem_next,
    output logic        q_bit
);

    logic [24:0] diff_s;

    // Trial subtraction; keep the difference only when it does not go negative.
    always_comb begin
        diff_s = rem - {1'b0, divisor};
        q_bit  = (rem >= {1'b0, divisor});
        if (q_bit) begin
            rem_next = {diff_s[23:0], 1'b0};
        end else begin
            rem_next = {rem[23:0], 1'b0};
        end
    end

endmodule

// File: rtl/fp_divider.sv
// IEEE-754 single-precision divider, multi-cycle restoring iteration.
// Define FPU_DIV_RNE_EN for round-to-nearest-even; otherwise results truncate.
module fp_divider
    import fpu_pkg::*;
#(
    parameter int LAT_FIXED = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] q,
    output logic [3:0]  flags,
    output logic        out_valid,
    input  logic        out_ready
);

    div_state_t         state_r;
    logic [31:0]        a_r;
    logic [31:0]        b_r;
    logic               sign_r;
    logic signed [9:0]  exp_r;
    logic [23:0]        div_r;
    logic [24:0]        rem_r;
    logic [25:0]        quo_r;
    logic [4:0]         cnt_r;
    logic               special_r;
    logic [31:0]        spec_q_r;
    logic [3:0]         spec_flags_r;
    logic [31:0]        q_r;
    logic [3:0]         flags_r;
    logic               out_valid_r;
    logic               in_ready_r;

    logic               sign_s;
    logic signed [9:0]  exp_unp_s;
    logic               spec_hit_s;
    logic [31:0]        spec_q_s;
    logic [3:0]         spec_flags_s;
    logic [24:0]        rem_next_s;
    logic               q_bit_s;

    logic [23:0]        mant_s;
    logic               guard_s;
    logic               rnd_s;
    logic               sticky_s;
    logic               inc_s;
    logic [24:0]        mant_rnd_s;
    logic [22:0]        frac_s;
    logic signed [9:0]  exp_n_s;
    logic signed [9:0]  exp_f_s;
    logic [31:0]        res_q_s;
    logic [3:0]         res_flags_s;

    fp_div_mant_iter u_iter (
        .rem      (rem_next_src()),
        .divisor  (div_r),
        .rem_next (rem_next_s),
        .q_bit    (q_bit_s)
    );

    function automatic logic [24:0] rem_next_src();
        return rem_r;
    endfunction

    // Unpack sign/exponent and classify the captured operands.
    always_comb begin
        sign_s       = a_r[31] ^ b_r[31];
        exp_unp_s    = {2'b00, a_r[30:23]} - {2'b00, b_r[30:23]} + BIAS;
        spec_hit_s   = 1'b1;
        spec_q_s     = 32'd0;
        spec_flags_s = 4'd0;
        if (is_nan(a_r) || is_nan(b_r) || (is_zero(a_r) && is_zero(b_r)) ||
            (is_inf(a_r) && is_inf(b_r))) begin
            spec_q_s                    = QNAN;
            spec_flags_s[FLAG_INVALID]  = 1'b1;
        end else if (is_inf(a_r)) begin
            spec_q_s = POS_INF | {sign_s, 31'd0};
        end else if (is_zero(b_r)) begin
            spec_q_s                    = POS_INF | {sign_s, 31'd0};
            spec_flags_s[FLAG_DIV_ZERO] = 1'b1;
        end else if (is_inf(b_r) || is_zero(a_r)) begin
            spec_q_s = {sign_s, 31'd0};
        end else begin
            spec_hit_s = 1'b0;
        end
    end

    // Normalise, round, renormalise and range-check the raw quotient.
    always_comb begin
        sticky_s = |rem_r;
        if (quo_r[25]) begin
            mant_s  = quo_r[25:2];
            guard_s = quo_r[1];
            rnd_s   = quo_r[0];
            exp_n_s = exp_r;
        end else begin
            // The missing round bit is folded into the remainder sticky.
            mant_s  = quo_r[24:1];
            guard_s = quo_r[0];
            rnd_s   = 1'b0;
            exp_n_s = exp_r - 10'sd1;
        end
`ifdef FPU_DIV_RNE_EN
        inc_s = guard_s & (rnd_s | sticky_s | mant_s[0]);
`else
        inc_s = 1'b0;
`endif
        mant_rnd_s = {1'b0, mant_s} + {24'd0, inc_s};
        if (mant_rnd_s[24]) begin
            frac_s  = mant_rnd_s[23:1];
            exp_f_s = exp_n_s + 10'sd1;
        end else begin
            frac_s  = mant_rnd_s[22:0];
            exp_f_s = exp_n_s;
        end
        res_flags_s = 4'd0;
        if (special_r) begin
            res_q_s     = spec_q_r;
            res_flags_s = spec_flags_r;
        end else if (exp_f_s >= 10'sd255) begin
            res_q_s                      = POS_INF | {sign_r, 31'd0};
            res_flags_s[FLAG_OVERFLOW]   = 1'b1;
        end else if (exp_f_s <= 10'sd0) begin
            res_q_s                      = {sign_r, 31'd0};
            res_flags_s[FLAG_UNDERFLOW]  = 1'b1;
        end else begin
            res_q_s = {sign_r, exp_f_s[7:0], frac_s};
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            a_r          <= 32'd0;
            b_r          <= 32'd0;
            sign_r       <= 1'b0;
            exp_r        <= 10'sd0;
            div_r        <= 24'd0;
            rem_r        <= 25'd0;
            quo_r        <= 26'd0;
            cnt_r        <= 5'd0;
            special_r    <= 1'b0;
            spec_q_r     <= 32'd0;
            spec_flags_r <= 4'd0;
            q_r          <= 32'd0;
            flags_r      <= 4'd0;
            out_valid_r  <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_r        <= a;
                        b_r        <= b;
                        in_ready_r <= 1'b0;
                        state_r    <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_r       <= sign_s;
                    exp_r        <= exp_unp_s;
                    div_r        <= {1'b1, b_r[22:0]};
                    rem_r        <= {2'b01, a_r[22:0]};
                    quo_r        <= 26'd0;
                    cnt_r        <= 5'd0;
                    special_r    <= spec_hit_s;
                    spec_q_r     <= spec_q_s;
                    spec_flags_r <= spec_flags_s;
                    if (spec_hit_s && (LAT_FIXED == 0)) begin
                        // Early finish; out_valid follows one cycle later in DONE.
                        q_r     <= spec_q_s;
                        flags_r <= spec_flags_s;
                        state_r <= DONE;
                    end else begin
                        state_r <= ITER;
                    end
                end
                ITER: begin
                    rem_r <= rem_next_s;
                    quo_r <= {quo_r[24:0], q_bit_s};
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == ITER_LAST) begin
                        state_r <= ROUND;
                    end
                end
                ROUND: begin
                    q_r         <= res_q_s;
                    flags_r     <= res_flags_s;
                    out_valid_r <= 1'b1;
                    state_r     <= DONE;
                end
                DONE: begin
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign q         = q_r;
    assign flags     = flags_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_fp_divider.sv
// Directed scoreboard bench for fp_divider: a fixed-latency instance and an
// early-finish (LAT_FIXED=0) instance sharing the operand buses.
module tb_fp_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic        in_valid, in_valid_el;
    logic        out_ready, out_ready_el;
    logic        in_ready, in_ready_el;
    logic [31:0] q, q_el;
    logic [3:0]  flags, flags_el;
    logic        out_valid, out_valid_el;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] q;
        logic [3:0]  f;
    } exp_t;
    exp_t sb[$];

    logic        sel;
    logic        sel_ov, sel_ir;
    logic [31:0] sel_q;
    logic [3:0]  sel_f;
    assign sel_ov = sel ? out_valid_el : out_valid;
    assign sel_ir = sel ? in_ready_el  : in_ready;
    assign sel_q  = sel ? q_el         : q;
    assign sel_f  = sel ? flags_el     : flags;

    fp_divider #(.LAT_FIXED(1)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
        .in_ready(in_ready), .q(q), .flags(flags), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    fp_divider #(.LAT_FIXED(0)) dut_el (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid_el),
        .in_ready(in_ready_el), .q(q_el), .flags(flags_el), .out_valid(out_valid_el),
        .out_ready(out_ready_el)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic set_valid(input logic v);
        if (sel) in_valid_el = v;
        else     in_valid    = v;
    endtask

    task automatic set_ready(input logic v);
        if (sel) out_ready_el = v;
        else     out_ready    = v;
    endtask

    // Drive one pair, wait for the result, compare against the scoreboard, handshake.
    task automatic run_op(input logic s, input logic [31:0] aa, input logic [31:0] bb,
                          input logic [31:0] eq, input logic [3:0] ef, input int lat,
                          input int hold, input int pulse_at, input string tag);
        int   cycles;
        exp_t e;
        sel = s;
        sb.push_back('{q: eq, f: ef});
        #1;
        check({tag, "_in_ready_idle"}, {31'd0, sel_ir}, 32'd1);
        a = aa;
        b = bb;
        set_valid(1'b1);
        @(posedge clk);
        @(negedge clk);
        set_valid(1'b0);
        a = $urandom;
        b = $urandom;
        cycles = 0;
        while (!sel_ov && cycles < 200) begin
            if (pulse_at != 0 && cycles == pulse_at) begin
                a = 32'h3F800000;
                b = 32'h00000000;
                set_valid(1'b1);
            end else begin
                set_valid(1'b0);
            end
            @(negedge clk);
            cycles++;
        end
        set_valid(1'b0);
        check({tag, "_out_valid"}, {31'd0, sel_ov}, 32'd1);
        check({tag, "_latency"}, cycles, lat);
        e = (sb.size() > 0) ? sb.pop_front() : '{q: 32'hDEADBEEF, f: 4'hF};
        check({tag, "_q"}, sel_q, e.q);
        check({tag, "_flags"}, {28'd0, sel_f}, {28'd0, e.f});
        for (int i = 0; i < hold; i++) begin
            set_ready(1'b0);
            @(negedge clk);
            check({tag, "_hold_q"}, sel_q, e.q);
            check({tag, "_hold_valid_ready"}, {30'd0, sel_ov, sel_ir}, 32'd2);
        end
        set_ready(1'b1);
        @(posedge clk);
        @(negedge clk);
        set_ready(1'b0);
        check({tag, "_drop_valid_ready"}, {30'd0, sel_ov, sel_ir}, 32'd1);
        if (pulse_at != 0) begin
            logic seen = 1'b0;
            for (int i = 0; i < 35; i++) begin
                @(negedge clk);
                seen = seen | sel_ov;
            end
            check({tag, "_no_spurious"}, {31'd0, seen}, 32'd0);
        end
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0;
        in_valid = 1'b0; in_valid_el = 1'b0;
        out_ready = 1'b0; out_ready_el = 1'b0;
        a = 32'd0; b = 32'd0; sel = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_q", q, 32'd0);
        check("reset_flags", {28'd0, flags}, 32'd0);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        // Normal operands, fixed 28-cycle latency.
        run_op(1'b0, 32'h41200000, 32'h40A00000, 32'h40000000, 4'b0000, 28, 0, 0, "ten_div_five");
`ifdef FPU_DIV_RNE_EN
        run_op(1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28, 0, 0, "one_third");
`else
        run_op(1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 28, 0, 0, "one_third");
`endif
        run_op(1'b0, 32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 28, 0, 0, "neg_six_div_two");
        run_op(1'b0, 32'h40E00000, 32'h40000000, 32'h40600000, 4'b0000, 28, 0, 0, "seven_div_two");

        // Special operands and range limits.
        run_op(1'b0, 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 28, 0, 0, "div_by_zero");
        run_op(1'b0, 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 28, 0, 0, "zero_div_zero");
        run_op(1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 28, 0, 0, "nan_operand");
        run_op(1'b0, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 28, 0, 0, "inf_div_inf");
        run_op(1'b0, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 28, 0, 0, "neg_inf_div_two");
        run_op(1'b0, 32'h40400000, 32'h7F800000, 32'h00000000, 4'b0000, 28, 0, 0, "three_div_inf");
        run_op(1'b0, 32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 28, 0, 0, "denorm_dividend");
        run_op(1'b0, 32'h3F800000, 32'h80000001, 32'hFF800000, 4'b0100, 28, 0, 0, "neg_denorm_divisor");
        run_op(1'b0, 32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 28, 0, 0, "overflow");
        run_op(1'b0, 32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 28, 0, 0, "underflow");

        // Handshake: stall in DONE, and an ignored in_valid pulse mid-ITER.
        run_op(1'b0, 32'h41200000, 32'h40A00000, 32'h40000000, 4'b0000, 28, 5, 0, "stall_done");
        run_op(1'b0, 32'h41200000, 32'h40A00000, 32'h40000000, 4'b0000, 28, 0, 12, "pulse_mid_iter");

        // Early-finish instance.
        run_op(1'b1, 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 2, 0, 0, "el_div_by_zero");
        run_op(1'b1, 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 2, 0, 0, "el_zero_div_zero");
        run_op(1'b1, 32'h41200000, 32'h40A00000, 32'h40000000, 4'b0000, 28, 0, 0, "el_normal");

        // Reset in the middle of an operation abandons it.
        sel = 1'b0;
        a = 32'h41200000; b = 32'h40A00000; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset_q", q, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("midreset_no_result", {31'd0, seen}, 32'd0);
        run_op(1'b0, 32'h41200000, 32'h40A00000, 32'h40000000, 4'b0000, 28, 0, 0, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_divider.md
FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001 The block SHALL have parameter LAT_FIXED, default 1, which selects fixed latency (1) or an early finish for special operands (0).
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port a, input, 32 bits: dividend in IEEE-754 single format.
REQ-005 Port b, input, 32 bits: divisor in IEEE-754 single format.
REQ-006 Port in_valid, input, 1 bit: a and b are valid.
REQ-007 Port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-008 Port q, output, 32 bits: quotient a/b.
REQ-009 Port flags, output, 4 bits: {invalid, div_by_zero, overflow, underflow}.
REQ-010 Port out_valid, output, 1 bit: q and flags are valid.
REQ-011 Port out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-012 The FSM SHALL have states IDLE, UNPACK, ITER, ROUND and DONE; transitions are IDLE->UNPACK on in_valid&&in_ready, UNPACK->ITER, ITER->ROUND when the iteration count reaches 25, ROUND->DONE, and DONE->IDLE on out_ready.
REQ-013 in_ready SHALL be 1 only in IDLE; a and b SHALL be captured on the accept edge and ignored at all other times.
REQ-014 UNPACK SHALL compute sign = a[31]^b[31] and exponent = ea-eb+127 (signed, 10 bits), and SHALL load the mantissas with the hidden 1.
REQ-015 The block SHALL treat denormal inputs as signed zero (flush-to-zero).
REQ-016 ITER SHALL run one radix-2 restoring step per cycle for 26 cycles, producing 24 quotient bits plus guard and round; the sticky bit SHALL be the OR of the nonzero final remainder.
REQ-017 ROUND SHALL normalise the quotient: if quotient bit 25 is 0, shift left by 1 and decrement the exponent.
REQ-018 ROUND SHALL apply the rounding mode selected in REQ-027/REQ-028.
REQ-019 ROUND SHALL renormalise on mantissa carry-out.
REQ-020 The exponent results of ROUND SHALL be:
- Exponent >= 255: ±inf (0x7F800000 | sign), overflow=1.
- Exponent <= 0: signed zero, underflow=1.
REQ-021 Special operands SHALL produce these results:
- NaN operand, 0/0 or inf/inf: 0x7FC00000, invalid=1.
- Finite nonzero/0: ±inf, div_by_zero=1.
- inf/finite: ±inf.
- finite/inf and 0/nonzero: ±0.
REQ-022 Latency SHALL be 28 cycles from the accept edge to out_valid for normal operands.
REQ-023 With LAT_FIXED=0, special operands SHALL go UNPACK->DONE, giving out_valid 2 cycles after accept; with LAT_FIXED=1 they SHALL take 28 cycles.
REQ-024 In DONE, q, flags and out_valid SHALL be held stable until out_ready=1; out_valid SHALL drop on the edge after the handshake, and in_ready SHALL rise on that same edge.
REQ-025 in_valid asserted while the block is busy SHALL have no effect; there is no queueing.

Reset
REQ-026 While rst_n=0, the block SHALL immediately force state=IDLE, in_ready=1 (once reset is released), out_valid=0, q=0, flags=0 and iteration count=0; an operation in progress SHALL be abandoned without output, and the first accept SHALL be possible on the first edge after rst_n rises.

Configuration
REQ-027 With macro FPU_DIV_RNE_EN defined, ROUND SHALL apply round-to-nearest-even using the guard, round and sticky bits.
REQ-028 Without FPU_DIV_RNE_EN, ROUND SHALL truncate (round toward zero); overflow SHALL still give inf.

Structure
REQ-029 Shared package fpu_pkg SHALL hold the FSM state enum, BIAS=127, QNAN=32'h7FC00000, POS_INF=32'h7F800000 and the flag bit indices.
REQ-030 Sub-module fp_div_mant_iter SHALL hold the combinational restoring step (remainder, divisor -> next remainder, quotient bit); fp_divider SHALL instantiate it once.

Verification
REQ-031 a=0x41200000, b=0x40A00000 -> q=0x40000000, flags=0, out_valid exactly 28 cycles after accept.
REQ-032 a=0x3F800000, b=0x40400000 -> q=0x3EAAAAAB with FPU_DIV_RNE_EN, 0x3EAAAAAA without.
REQ-033 Special operands:
- a=0x3F800000, b=0x00000000 -> q=0x7F800000, div_by_zero=1.
- a=b=0 -> q=0x7FC00000, invalid=1.
- With LAT_FIXED=0, both results 2 cycles after accept.
REQ-034 Range limits:
- a=0x7F000000, b=0x3E800000 -> q=0x7F800000, overflow=1.
- a=0x00800000, b=0x40000000 -> q=0x00000000, underflow=1.
REQ-035 Handshake:
- Hold out_ready=0 for 5 cycles in DONE -> q and out_valid stable throughout, in_ready=0.
- in_valid pulsed mid-ITER -> ignored.
REQ-036 Reset mid-operation:
- Assert rst_n=0 at ITER cycle 10 -> out_valid=0 and no result produced.
- Next accepted pair 10.0/5.0 -> 0x40000000 after 28 cycles.
